if_aligner: RTL and testbench

IF_ALIGNER -- requirements
Module: if_aligner

---
 rtl/core_pkg.sv | 26 ++
 rtl/rvc_decompress.sv | 92 +++++++++
 rtl/if_aligner.sv | 181 ++++++++++++++++++
 tb/tb_if_aligner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared aligner state encoding, RV32 opcodes and NOP constant
package core_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_SKIP  = 2'd2
    } align_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;

    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    function automatic logic is_compressed(input logic [1:0] lsbs);
        return lsbs != 2'b11;
    endfunction

endpackage

// File: rtl/rvc_decompress.sv
// rtl/rvc_decompress.sv - combinational RV32C to RV32I expander with illegal flag
module rvc_decompress
    import core_pkg::*;
(
    input  logic [15:0] i_instr,
    output logic [31:0] o_instr,
    output logic        o_illegal
);
    logic [15:0] w_c;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rdp;
    logic [4:0]  w_rs1p;
    logic [2:0]  w_alu_f3;

    assign w_c    = i_instr;
    assign w_rd   = w_c[11:7];
    assign w_rs2  = w_c[6:2];
    assign w_rdp  = {2'b01, w_c[4:2]};
    assign w_rs1p = {2'b01, w_c[9:7]};
    assign w_alu_f3 = (w_c[6:5] == 2'b00) ? 3'b000 :
                      (w_c[6:5] == 2'b01) ? 3'b100 :
                      (w_c[6:5] == 2'b10) ? 3'b110 : 3'b111;

    always_comb begin
        o_instr   = {16'h0000, w_c};
        o_illegal = 1'b0;
        case ({w_c[15:13], w_c[1:0]})
            5'b000_00: begin
                o_instr   = {2'b00, w_c[10:7], w_c[12:11], w_c[5], w_c[6], 2'b00, 5'd2, 3'b000, w_rdp, OPC_OP_IMM};
                o_illegal = (w_c[12:5] == 8'h00);
            end
            5'b010_00: o_instr = {5'b0, w_c[5], w_c[12:10], w_c[6], 2'b00, w_rs1p, 3'b010, w_rdp, OPC_LOAD};
            5'b110_00: o_instr = {5'b0, w_c[5], w_c[12], w_rdp, w_rs1p, 3'b010, w_c[11:10], w_c[6], 2'b00, OPC_STORE};
            5'b000_01: o_instr = {{7{w_c[12]}}, w_c[6:2], w_rd, 3'b000, w_rd, OPC_OP_IMM};
            5'b001_01, 5'b101_01:
                o_instr = {w_c[12], w_c[8], w_c[10:9], w_c[6], w_c[7], w_c[2], w_c[11], w_c[5:3],
                           {9{w_c[12]}}, 4'b0000, ~w_c[15], OPC_JAL};
            5'b010_01: o_instr = {{7{w_c[12]}}, w_c[6:2], 5'd0, 3'b000, w_rd, OPC_OP_IMM};
            5'b011_01: begin
                // rd==x2 selects C.ADDI16SP, otherwise C.LUI; both reserve a zero immediate
                if (w_rd == 5'd2) begin
                    o_instr = {{3{w_c[12]}}, w_c[4:3], w_c[5], w_c[2], w_c[6], 4'b0000, 5'd2, 3'b000, 5'd2, OPC_OP_IMM};
                end else begin
                    o_instr = {{15{w_c[12]}}, w_c[6:2], w_rd, OPC_LUI};
                end
                o_illegal = ({w_c[12], w_c[6:2]} == 6'd0);
            end
            5'b100_01: begin
                case (w_c[11:10])
                    2'b00, 2'b01: begin
                        o_instr   = {1'b0, w_c[10], 5'b00000, w_c[6:2], w_rs1p, 3'b101, w_rs1p, OPC_OP_IMM};
                        o_illegal = w_c[12];
                    end
                    2'b10: o_instr = {{7{w_c[12]}}, w_c[6:2], w_rs1p, 3'b111, w_rs1p, OPC_OP_IMM};
                    default: begin
                        o_instr   = {1'b0, (w_c[6:5] == 2'b00), 5'b00000, w_rdp, w_rs1p, w_alu_f3, w_rs1p, OPC_OP};
                        o_illegal = w_c[12];
                    end
                endcase
            end
            5'b110_01, 5'b111_01:
                o_instr = {{4{w_c[12]}}, w_c[6:5], w_c[2], 5'd0, w_rs1p, 2'b00, w_c[13],
                           w_c[11:10], w_c[4:3], w_c[12], OPC_BRANCH};
            5'b000_10: begin
                o_instr   = {7'b0, w_c[6:2], w_rd, 3'b001, w_rd, OPC_OP_IMM};
                o_illegal = w_c[12];
            end
            5'b010_10: begin
                o_instr   = {4'b0, w_c[3:2], w_c[12], w_c[6:4], 2'b00, 5'd2, 3'b010, w_rd, OPC_LOAD};
                o_illegal = (w_rd == 5'd0);
            end
            5'b100_10: begin
                if (!w_c[12]) begin
                    if (w_rs2 == 5'd0) begin
                        o_instr   = {12'b0, w_rd, 3'b000, 5'd0, OPC_JALR};
                        o_illegal = (w_rd == 5'd0);
                    end else begin
                        o_instr = {7'b0, w_rs2, 5'd0, 3'b000, w_rd, OPC_OP};
                    end
                end else if (w_rs2 == 5'd0) begin
                    o_instr = (w_rd == 5'd0) ? INSTR_EBREAK : {12'b0, w_rd, 3'b000, 5'd1, OPC_JALR};
                end else begin
                    o_instr = {7'b0, w_rs2, w_rd, 3'b000, w_rd, OPC_OP};
                end
            end
            5'b110_10: o_instr = {4'b0, w_c[8:7], w_c[12], w_rs2, 5'd2, 3'b010, w_c[11:9], 2'b00, OPC_STORE};
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/if_aligner.sv
// rtl/if_aligner.sv - fetch-word to instruction aligner; RVC_EN adds compressed alignment/expansion
module if_aligner
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic [31:0] fetch_addr_o,
    input  logic [31:0] fetch_data_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_c_o,
    output logic        illegal_o,
    output logic        instr_valid_o,
    input  logic        id_ready_i
);
    logic [31:0] r_fetch_addr;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_valid;
    logic        r_c;
    logic        r_ill;
    logic        w_advance;
    logic        w_hs;
    logic        w_emit;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_c_nxt;
    logic        w_ill_nxt;

    assign w_advance = !r_valid || id_ready_i;
    assign w_hs      = fetch_valid_i && fetch_ready_o;

`ifdef RVC_EN
    align_state_e r_state;
    align_state_e w_state_nxt;
    logic [15:0]  r_hold;
    logic [31:0]  r_hold_pc;
    logic [15:0]  w_dec_in;
    logic [31:0]  w_dec_instr;
    logic         w_dec_ill;
    logic         w_load_hold;
    logic         w_hold_c;
    logic         w_unused_flush_lsb;

    assign w_unused_flush_lsb = flush_pc_i[0];
    assign w_hold_c      = is_compressed(r_hold[1:0]);
    // A held compressed halfword is emitted on its own, so no new word may be taken that cycle
    assign fetch_ready_o = w_advance && !flush_i && !(r_state == ST_HALF && w_hold_c);
    assign w_dec_in      = (r_state == ST_HALF) ? r_hold : fetch_data_i[15:0];

    rvc_decompress u_rvc_decompress (
        .i_instr   (w_dec_in),
        .o_instr   (w_dec_instr),
        .o_illegal (w_dec_ill)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_load_hold = 1'b0;
        w_instr_nxt = r_instr;
        w_pc_nxt    = r_pc;
        w_c_nxt     = 1'b0;
        w_ill_nxt   = 1'b0;
        if (flush_i) begin
            w_state_nxt = flush_pc_i[1] ? ST_SKIP : ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_hs) begin
                    w_emit   = 1'b1;
                    w_pc_nxt = r_fetch_addr;
                    if (is_compressed(fetch_data_i[1:0])) begin
                        w_instr_nxt = w_dec_instr;
                        w_c_nxt     = 1'b1;
                        w_ill_nxt   = w_dec_ill;
                        w_load_hold = 1'b1;
                        w_state_nxt = ST_HALF;
                    end else begin
                        w_instr_nxt = fetch_data_i;
                    end
                end
                ST_HALF: if (w_hold_c) begin
                    if (w_advance) begin
                        w_emit      = 1'b1;
                        w_instr_nxt = w_dec_instr;
                        w_pc_nxt    = r_hold_pc;
                        w_c_nxt     = 1'b1;
                        w_ill_nxt   = w_dec_ill;
                        w_state_nxt = ST_EMPTY;
                    end
                end else if (w_hs) begin
                    w_emit      = 1'b1;
                    w_instr_nxt = {fetch_data_i[15:0], r_hold};
                    w_pc_nxt    = r_hold_pc;
                    w_load_hold = 1'b1;
                end
                ST_SKIP: if (w_hs) begin
                    w_load_hold = 1'b1;
                    w_state_nxt = ST_HALF;
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold    <= 16'h0000;
            r_hold_pc <= 32'h0000_0000;
        end else if (flush_i) begin
            r_hold    <= 16'h0000;
            r_hold_pc <= 32'h0000_0000;
        end else if (w_load_hold) begin
            r_hold    <= fetch_data_i[31:16];
            r_hold_pc <= r_fetch_addr + 32'd2;
        end
    end
`else
    logic w_unused_flush_lsbs;

    assign w_unused_flush_lsbs = ^flush_pc_i[1:0];
    assign fetch_ready_o       = w_advance && !flush_i;

    always_comb begin
        w_emit      = w_hs;
        w_instr_nxt = fetch_data_i;
        w_pc_nxt    = r_fetch_addr;
        w_c_nxt     = 1'b0;
        w_ill_nxt   = 1'b0;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_addr <= RESET_PC;
            r_valid      <= 1'b0;
            r_instr      <= INSTR_NOP;
            r_pc         <= 32'h0000_0000;
            r_c          <= 1'b0;
            r_ill        <= 1'b0;
        end else if (flush_i) begin
            r_fetch_addr <= {flush_pc_i[31:2], 2'b00};
            r_valid      <= 1'b0;
        end else begin
            if (w_hs) begin
                r_fetch_addr <= r_fetch_addr + 32'd4;
            end
            if (w_advance) begin
                r_valid <= w_emit;
                if (w_emit) begin
                    r_instr <= w_instr_nxt;
                    r_pc    <= w_pc_nxt;
                    r_c     <= w_c_nxt;
                    r_ill   <= w_ill_nxt;
                end
            end
        end
    end

    assign fetch_addr_o  = r_fetch_addr;
    assign instr_o       = r_instr;
    assign pc_o          = r_pc;
    assign instr_c_o     = r_c;
    assign illegal_o     = r_ill;
    assign instr_valid_o = r_valid;

endmodule

// File: tb/tb_if_aligner.sv
// tb/tb_if_aligner.sv - scoreboard bench for if_aligner, expectations follow the RVC_EN build setting
module tb_if_aligner;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = 32'h0;
    logic [31:0] fetch_addr_o;
    logic [31:0] fetch_data_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_c_o;
    logic        illegal_o;
    logic        instr_valid_o;
    logic        id_ready_i = 1'b1;

    logic [31:0] mem [0:127];
    logic        fv_en = 1'b0;
    logic [31:0] win_lo = 32'h0;
    logic [31:0] win_hi = 32'h0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        c;
        logic        ill;
        logic        any;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    if_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i),
        .fetch_addr_o  (fetch_addr_o),
        .fetch_data_i  (fetch_data_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_c_o     (instr_c_o),
        .illegal_o     (illegal_o),
        .instr_valid_o (instr_valid_o),
        .id_ready_i    (id_ready_i)
    );

    always #5 clk_i = ~clk_i;

    assign fetch_data_i  = mem[fetch_addr_o[8:2]];
    assign fetch_valid_i = fv_en && (fetch_addr_o >= win_lo) && (fetch_addr_o < win_hi);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                        input logic c, input logic ill, input logic any);
        exp_t e;
        e.instr = instr; e.pc = pc; e.c = c; e.ill = ill; e.any = any;
        exp_q.push_back(e);
    endtask

    task automatic flush_to(input logic [31:0] target, input logic [31:0] lo, input logic [31:0] hi);
        @(posedge clk_i); #1;
        flush_i = 1'b1; flush_pc_i = target; win_lo = lo; win_hi = hi;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_addr", fetch_addr_o, {target[31:2], 2'b00});
        chk("flush_valid", {31'd0, instr_valid_o}, 32'd0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk(name, {31'd0, instr_valid_o}, 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        repeat (3) @(negedge clk_i);
        chk(name, exp_q.size(), 32'd0);
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && instr_valid_o && id_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got pc=%08h instr=%08h want none", pc_o, instr_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ((!mon_e.any && instr_o !== mon_e.instr) || pc_o !== mon_e.pc ||
                    instr_c_o !== mon_e.c || illegal_o !== mon_e.ill) begin
                    errors++;
                    $display("FAIL out got instr=%08h pc=%08h c=%0b ill=%0b want instr=%08h pc=%08h c=%0b ill=%0b",
                             instr_o, pc_o, instr_c_o, illegal_o, mon_e.instr, mon_e.pc, mon_e.c, mon_e.ill);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013;
        mem[0]  = 32'h0010_8093;
        mem[4]  = 32'h0001_0085;
        mem[8]  = 32'h8093_0001;
        mem[9]  = 32'h0000_0010;
        mem[24] = 32'h0010_8093;
        mem[25] = 32'h0020_8113;
        mem[26] = 32'h0031_0193;
        mem[32] = 32'h0010_8093;
        mem[36] = 32'h0051_0293;
        mem[64] = 32'h0085_0001;

        // reset values
        repeat (2) @(negedge clk_i);
        chk("rst_addr", fetch_addr_o, 32'h0);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'h0000_0013);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_c_ill", {30'd0, instr_c_o, illegal_o}, 32'd0);

        // single 32-bit word, one-cycle latency
        push(32'h0010_8093, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1; win_lo = 32'h0; win_hi = 32'h4; fv_en = 1'b1;
        @(negedge clk_i);
        chk("t1_ready", {31'd0, fetch_ready_o}, 32'd1);
        chk("t1_valid_pre", {31'd0, instr_valid_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("t1_valid_post", {31'd0, instr_valid_o}, 32'd1);
        drain("t1_drain");

        // two compressed halves in one word
`ifdef RVC_EN
        push(32'h0010_8093, 32'h10, 1'b1, 1'b0, 1'b0);
        push(32'h0000_0013, 32'h12, 1'b1, 1'b0, 1'b0);
`else
        push(32'h0001_0085, 32'h10, 1'b0, 1'b0, 1'b0);
`endif
        flush_to(32'h10, 32'h10, 32'h14);
        wait_valid("t2_valid");
`ifdef RVC_EN
        chk("t2_ready_half", {31'd0, fetch_ready_o}, 32'd0);
`else
        chk("t2_ready_half", {31'd0, fetch_ready_o}, 32'd1);
`endif
        drain("t2_drain");

        // c.nop, word-spanning 32-bit, then illegal 16'h0000
`ifdef RVC_EN
        push(32'h0000_0013, 32'h20, 1'b1, 1'b0, 1'b0);
        push(32'h0010_8093, 32'h22, 1'b0, 1'b0, 1'b0);
        push(32'h0, 32'h26, 1'b1, 1'b1, 1'b1);
`else
        push(32'h8093_0001, 32'h20, 1'b0, 1'b0, 1'b0);
        push(32'h0000_0010, 32'h24, 1'b0, 1'b0, 1'b0);
`endif
        flush_to(32'h20, 32'h20, 32'h28);
        drain("t3_drain");

        // redirect to a halfword-aligned target
`ifdef RVC_EN
        push(32'h0010_8093, 32'h102, 1'b1, 1'b0, 1'b0);
`else
        push(32'h0085_0001, 32'h100, 1'b0, 1'b0, 1'b0);
`endif
        flush_to(32'h102, 32'h100, 32'h104);
        drain("t4_drain");

        // downstream stall freezes outputs and fetch
        push(32'h0010_8093, 32'h60, 1'b0, 1'b0, 1'b0);
        push(32'h0020_8113, 32'h64, 1'b0, 1'b0, 1'b0);
        push(32'h0031_0193, 32'h68, 1'b0, 1'b0, 1'b0);
        id_ready_i = 1'b0;
        flush_to(32'h60, 32'h60, 32'h6c);
        wait_valid("t5_valid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("t5_stall_instr", instr_o, 32'h0010_8093);
            chk("t5_stall_pc", pc_o, 32'h60);
            chk("t5_stall_ready", {31'd0, fetch_ready_o}, 32'd0);
            chk("t5_stall_addr", fetch_addr_o, 32'h64);
        end
        @(posedge clk_i); #1;
        id_ready_i = 1'b1;
        drain("t5_drain");

        // flush during stall drops the held instruction
        push(32'h0051_0293, 32'h90, 1'b0, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        id_ready_i = 1'b0;
        flush_to(32'h80, 32'h80, 32'h84);
        wait_valid("t6_valid");
        flush_to(32'h90, 32'h90, 32'h94);
        @(posedge clk_i); #1;
        id_ready_i = 1'b1;
        drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
